map_tile_fetch: RTL

MAP_TILE_FETCH -- requirements
Module: map_tile_fetch

---
 rtl/map_tile_fetch_if.sv | 40 ++++
 rtl/map_tile_fetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/map_tile_fetch_if.sv
// map_tile_fetch_if: timing strobes, tile-map RAM ports, update handshake and tile outputs
interface map_tile_fetch_if;
    logic [9:0] px;
    logic [9:0] py;
    logic       de_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] mem_raddr;
    logic [3:0] mem_rdata;
    logic       mem_we;
    logic [9:0] mem_waddr;
    logic [3:0] mem_wdata;
    logic       wr_req;
    logic [4:0] wr_tx;
    logic [4:0] wr_ty;
    logic [3:0] wr_code;
    logic       wr_ack;
    logic       wr_err;
    logic [3:0] sprite_code;
    logic [2:0] tile_sx;
    logic [2:0] tile_sy;
    logic       in_map;
    logic       de_out;
    logic       hsync_out;
    logic       vsync_out;

    modport slave (
        input  px, py, de_in, hsync_in, vsync_in, mem_rdata,
        input  wr_req, wr_tx, wr_ty, wr_code,
        output mem_raddr, mem_we, mem_waddr, mem_wdata, wr_ack, wr_err,
        output sprite_code, tile_sx, tile_sy, in_map, de_out, hsync_out, vsync_out
    );

    modport master (
        output px, py, de_in, hsync_in, vsync_in, mem_rdata,
        output wr_req, wr_tx, wr_ty, wr_code,
        input  mem_raddr, mem_we, mem_waddr, mem_wdata, wr_ack, wr_err,
        input  sprite_code, tile_sx, tile_sy, in_map, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/map_tile_fetch.sv
// map_tile_fetch: 3-stage pixel-to-tile fetch pipeline with blanking-only tile update port
module map_tile_fetch #(
    parameter int MAP_W  = 28,
    parameter int MAP_H  = 31,
    parameter int MAP_X0 = 208,
    parameter int MAP_Y0 = 116
) (
    input logic clk,
    input logic rst_n,
    map_tile_fetch_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_BLANK, WRITE} state_t;

    localparam logic [10:0] X0  = 11'(MAP_X0);
    localparam logic [10:0] Y0  = 11'(MAP_Y0);
    localparam logic [10:0] XW  = 11'(8 * MAP_W);
    localparam logic [10:0] YH  = 11'(8 * MAP_H);
    localparam logic [9:0]  W10 = 10'(MAP_W);
    localparam logic [9:0]  H10 = 10'(MAP_H);

    logic [10:0] rx, ry;
    logic        hit;
    logic [9:0]  raddr;
    logic        s1_hit, s1_de, s1_hs, s1_vs;
    logic [2:0]  s1_sx, s1_sy;
    logic        s2_hit, s2_de, s2_hs, s2_vs;
    logic [2:0]  s2_sx, s2_sy;

    state_t      state, next;
    logic [4:0]  lat_tx, lat_ty;
    logic [3:0]  lat_code;
    logic        latch, we_d, ack_d, err_d, bad, blank;
    logic [9:0]  waddr_d;

    // Map-relative coordinates; a negative offset shows up as bit 10 set
    always_comb begin
        rx    = {1'b0, bus.px} - X0;
        ry    = {1'b0, bus.py} - Y0;
        hit   = !rx[10] && !ry[10] && rx < XW && ry < YH;
        raddr = 10'(ry[9:3]) * W10 + 10'(rx[9:3]);
    end

    // Stage 1: issue the RAM read and capture the side-band for this pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_raddr <= '0;
            s1_hit <= 1'b0;
            s1_sx  <= '0;
            s1_sy  <= '0;
            s1_de  <= 1'b0;
            s1_hs  <= 1'b0;
            s1_vs  <= 1'b0;
        end else begin
            if (hit)
                bus.mem_raddr <= raddr;
            s1_hit <= hit;
            s1_sx  <= rx[2:0];
            s1_sy  <= ry[2:0];
            s1_de  <= bus.de_in;
            s1_hs  <= bus.hsync_in;
            s1_vs  <= bus.vsync_in;
        end
    end

    // Stage 2: side-band waits here while the RAM produces read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_hit <= 1'b0;
            s2_sx  <= '0;
            s2_sy  <= '0;
            s2_de  <= 1'b0;
            s2_hs  <= 1'b0;
            s2_vs  <= 1'b0;
        end else begin
            s2_hit <= s1_hit;
            s2_sx  <= s1_sx;
            s2_sy  <= s1_sy;
            s2_de  <= s1_de;
            s2_hs  <= s1_hs;
            s2_vs  <= s1_vs;
        end
    end

    // Stage 3: merge RAM data with side-band; off-map pixels get the blank code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sprite_code <= 4'b1111;
            bus.tile_sx     <= '0;
            bus.tile_sy     <= '0;
            bus.in_map      <= 1'b0;
            bus.de_out      <= 1'b0;
            bus.hsync_out   <= 1'b0;
            bus.vsync_out   <= 1'b0;
        end else begin
            bus.sprite_code <= s2_hit ? bus.mem_rdata : 4'b1111;
            bus.tile_sx     <= s2_sx;
            bus.tile_sy     <= s2_sy;
            bus.in_map      <= s2_hit;
            bus.de_out      <= s2_de;
            bus.hsync_out   <= s2_hs;
            bus.vsync_out   <= s2_vs;
        end
    end

    // Update FSM: validate and latch a request, then write once the fetch pipeline is idle
    always_comb begin
        next    = state;
        latch   = 1'b0;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        bad     = 10'(bus.wr_tx) >= W10 || 10'(bus.wr_ty) >= H10;
        blank   = !bus.de_in && !s1_de && !s2_de;
        waddr_d = 10'(lat_ty) * W10 + 10'(lat_tx);
        case (state)
            IDLE: begin
                if (bus.wr_req && !bus.wr_err) begin
                    err_d = bad;
                    latch = !bad;
                    next  = bad ? IDLE : WAIT_BLANK;
                end
            end
            WAIT_BLANK: begin
                we_d  = blank;
                ack_d = blank;
                next  = blank ? WRITE : WAIT_BLANK;
            end
            WRITE:   next = IDLE;
            default: next = IDLE;
        endcase
    end

    // FSM state and registered write-port/handshake outputs; mem_we is high exactly while in WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lat_tx        <= '0;
            lat_ty        <= '0;
            lat_code      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            bus.wr_ack    <= 1'b0;
            bus.wr_err    <= 1'b0;
        end else begin
            state      <= next;
            bus.mem_we <= we_d;
            bus.wr_ack <= ack_d;
            bus.wr_err <= err_d;
            if (latch) begin
                lat_tx   <= bus.wr_tx;
                lat_ty   <= bus.wr_ty;
                lat_code <= bus.wr_code;
            end
            if (we_d) begin
                bus.mem_waddr <= waddr_d;
                bus.mem_wdata <= lat_code;
            end
        end
    end
endmodule
